// File: rtl/func_table_pkg.sv
// Shared types and constants for the truth-table function engine.
package func_table_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] DEF_RESET_TBL = 16'hAAF8;

    function automatic int tbl_w(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/func_sweep_ctr.sv
// Sweep index counter with zero accumulator (and golden-mismatch accumulator
// when FUNC_TABLE_GOLDEN_CHECK_EN is defined).
module func_sweep_ctr
    import func_table_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_enable,
    input  logic            i_bit,
`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
    input  logic            i_gold,
    output logic            o_mis_beat,
    output logic [N_IN:0]   o_mis_count,
`endif
    output logic [N_IN-1:0] o_idx,
    output logic            o_last,
    output logic [N_IN:0]   o_count
);

    logic [N_IN-1:0] r_idx;
    logic [N_IN:0]   r_zero_cnt;
    logic [N_IN:0]   w_zero_inc;

    // Counts include the beat currently on the output, so the final edge can publish them directly.
    assign w_zero_inc = (N_IN+1)'(i_enable & ~i_bit);
    assign o_count    = r_zero_cnt + w_zero_inc;
    assign o_idx      = r_idx;
    assign o_last     = (r_idx == {N_IN{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_zero_cnt <= '0;
        end else if (i_start) begin
            r_idx      <= '0;
            r_zero_cnt <= '0;
        end else if (i_enable) begin
            r_idx      <= r_idx + N_IN'(1);
            r_zero_cnt <= o_count;
        end
    end

`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
    logic [N_IN:0] r_mis_cnt;

    assign o_mis_beat  = i_enable & (i_bit ^ i_gold);
    assign o_mis_count = r_mis_cnt + (N_IN+1)'(o_mis_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis_cnt <= '0;
        end else if (i_start) begin
            r_mis_cnt <= '0;
        end else if (i_enable) begin
            r_mis_cnt <= o_mis_count;
        end
    end
`endif

endmodule

// File: rtl/func_table_engine.sv
// Loadable N-input truth-table engine: single-vector evaluation plus exhaustive sweep.
// Optional golden-table comparison enabled by defining FUNC_TABLE_GOLDEN_CHECK_EN.
module func_table_engine
    import func_table_pkg::*;
#(
    parameter  int               N_IN      = 4,
    localparam int               TBL_W     = tbl_w(N_IN),
    parameter  logic [255:0]     RESET_TBL = 256'(DEF_RESET_TBL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [TBL_W-1:0] cfg_tbl,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_IN-1:0]  req_vec,
    input  logic             sweep_start,
    output logic             busy,
    output logic             rsp_valid,
    output logic [N_IN-1:0]  rsp_vec,
    output logic             rsp_f,
    output logic             sweep_done,
`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
    input  logic             gold_we,
    input  logic [TBL_W-1:0] gold_tbl,
    output logic             mismatch,
    output logic [N_IN:0]    mismatch_cnt,
`endif
    output logic [N_IN:0]    maxterm_cnt
);

    state_t            r_state;
    logic [TBL_W-1:0]  r_tbl;
    logic              r_vld_p1;
    logic [N_IN-1:0]   r_rsp_vec_p1;
    logic              r_rsp_f_p1;
    logic [N_IN:0]     r_maxterm;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_start;
    logic              w_sweeping;
    logic              w_cur_bit;
    logic              w_last;
    logic [N_IN-1:0]   w_idx;
    logic [N_IN:0]     w_count;

    assign w_req_ready = (r_state == IDLE) && !sweep_start;
    assign w_accept    = req_valid && w_req_ready;
    assign w_start     = (r_state == IDLE) && sweep_start;
    assign w_sweeping  = (r_state == SWEEP);
    assign w_cur_bit   = r_tbl[w_idx];

`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
    logic [TBL_W-1:0]  r_gold;
    logic              r_mismatch;
    logic [N_IN:0]     r_mis_pub;
    logic              w_mis_beat;
    logic [N_IN:0]     w_mis_count;

    func_sweep_ctr #(.N_IN(N_IN)) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_enable   (w_sweeping),
        .i_bit      (w_cur_bit),
        .i_gold     (r_gold[w_idx]),
        .o_mis_beat (w_mis_beat),
        .o_mis_count(w_mis_count),
        .o_idx      (w_idx),
        .o_last     (w_last),
        .o_count    (w_count)
    );

    // A fresh golden table restarts the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gold     <= RESET_TBL[TBL_W-1:0];
            r_mismatch <= 1'b0;
            r_mis_pub  <= '0;
        end else begin
            if (gold_we) begin
                r_gold     <= gold_tbl;
                r_mismatch <= 1'b0;
            end else if (w_mis_beat) begin
                r_mismatch <= 1'b1;
            end
            if (w_sweeping && w_last) begin
                r_mis_pub <= w_mis_count;
            end
        end
    end

    assign mismatch     = r_mismatch;
    assign mismatch_cnt = r_mis_pub;
`else
    func_sweep_ctr #(.N_IN(N_IN)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_enable(w_sweeping),
        .i_bit   (w_cur_bit),
        .o_idx   (w_idx),
        .o_last  (w_last),
        .o_count (w_count)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tbl     <= RESET_TBL[TBL_W-1:0];
            r_maxterm <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_we) begin
                        r_tbl <= cfg_tbl;
                    end
                    if (sweep_start) begin
                        r_state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (w_last) begin
                        r_state   <= DONE;
                        r_maxterm <= w_count;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Eval stage p1: response one cycle after accept, reading the pre-write table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1     <= 1'b0;
            r_rsp_vec_p1 <= '0;
            r_rsp_f_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_rsp_vec_p1 <= req_vec;
                r_rsp_f_p1   <= r_tbl[req_vec];
            end
        end
    end

    assign req_ready   = w_req_ready;
    assign busy        = w_sweeping;
    assign sweep_done  = (r_state == DONE);
    assign rsp_valid   = w_sweeping | r_vld_p1;
    assign rsp_vec     = w_sweeping ? w_idx : r_rsp_vec_p1;
    assign rsp_f       = w_sweeping ? w_cur_bit : r_rsp_f_p1;
    assign maxterm_cnt = r_maxterm;

endmodule

// File: tb/tb_func_table_engine.sv
// Directed self-checking bench for func_table_engine (N_IN = 4); golden tests
// are included when FUNC_TABLE_GOLDEN_CHECK_EN is defined.
module tb_func_table_engine;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_tbl = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_vec = '0;
    logic        sweep_start = 1'b0;
    logic        busy;
    logic        rsp_valid;
    logic [3:0]  rsp_vec;
    logic        rsp_f;
    logic        sweep_done;
    logic [4:0]  maxterm_cnt;
`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
    logic        gold_we = 1'b0;
    logic [15:0] gold_tbl = '0;
    logic        mismatch;
    logic [4:0]  mismatch_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    func_table_engine #(.N_IN(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_tbl     (cfg_tbl),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_vec     (req_vec),
        .sweep_start (sweep_start),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_vec     (rsp_vec),
        .rsp_f       (rsp_f),
        .sweep_done  (sweep_done),
`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
        .gold_we     (gold_we),
        .gold_tbl    (gold_tbl),
        .mismatch    (mismatch),
        .mismatch_cnt(mismatch_cnt),
`endif
        .maxterm_cnt (maxterm_cnt)
    );

    // Runs one sweep from IDLE and records what the stream looked like; returns in IDLE.
    task automatic do_sweep(input bit inject_cfg, output logic [15:0] f_seen, output int nbeats,
                            output bit order_ok, output bit done_ok, output logic [4:0] mcnt);
        bit fin;
        f_seen = '0; nbeats = 0; order_ok = 1'b1; done_ok = 1'b0; mcnt = '0; fin = 1'b0;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            cfg_we = 1'b0;
            if (rsp_valid && busy) begin
                if (rsp_vec != nbeats[3:0] || sweep_done) order_ok = 1'b0;
                f_seen[rsp_vec] = rsp_f;
                nbeats++;
                if (inject_cfg && nbeats == 6) begin
                    cfg_we  = 1'b1;
                    cfg_tbl = 16'hFFFF;
                end
            end else if (sweep_done) begin
                done_ok = (nbeats == 16) && !rsp_valid;
                mcnt    = maxterm_cnt;
                fin     = 1'b1;
            end else begin
                order_ok = 1'b0;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, rsp_valid, sweep_done, rsp_f, rsp_vec, maxterm_cnt} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b vld=%b done=%b f=%b vec=%0h cnt=%0d, expected all 0",
                     busy, rsp_valid, sweep_done, rsp_f, rsp_vec, maxterm_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_default_sweep;
        logic [15:0] f; int nb; bit ord, dn; logic [4:0] mc;
        do_sweep(1'b0, f, nb, ord, dn, mc);
        tests_run++;
        if (nb != 16 || !ord) begin
            tests_failed++;
            $display("FAIL default_beats: got %0d beats order_ok=%b expected 16 in order", nb, ord);
        end
        tests_run++;
        if (f !== 16'hAAF8) begin
            tests_failed++;
            $display("FAIL default_values: got %h expected aaf8", f);
        end
        tests_run++;
        if (!dn || mc !== 5'd7) begin
            tests_failed++;
            $display("FAIL default_done: got done_ok=%b maxterm=%0d expected 1/7", dn, mc);
        end
        tests_run++;
        if (sweep_done !== 1'b0 || busy !== 1'b0 || maxterm_cnt !== 5'd7 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL default_after: got done=%b busy=%b cnt=%0d rdy=%b expected 0/0/7/1",
                     sweep_done, busy, maxterm_cnt, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1;
        req_vec   = 4'b0011;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: got %b expected 1", req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_vec !== 4'b0011 || rsp_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: got vld=%b vec=%0h f=%b expected 1/3/1", rsp_valid, rsp_vec, rsp_f);
        end
        req_vec = 4'b1110;
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_vec !== 4'b1110 || rsp_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: got vld=%b vec=%0h f=%b expected 1/e/0", rsp_valid, rsp_vec, rsp_f);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got vld=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_cfg_write;
        logic [15:0] f; int nb; bit ord, dn; logic [4:0] mc;
        cfg_we = 1'b1; cfg_tbl = 16'h0000;
        req_valid = 1'b1; req_vec = 4'd3;
        @(negedge clk);
        cfg_we = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_old_table: got vld=%b f=%b expected 1/1", rsp_valid, rsp_f);
        end
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL cfg_new_table: got vld=%b f=%b expected 1/0", rsp_valid, rsp_f);
        end
        @(negedge clk);
        do_sweep(1'b1, f, nb, ord, dn, mc);
        tests_run++;
        if (!dn || !ord || f !== 16'h0000 || mc !== 5'd16) begin
            tests_failed++;
            $display("FAIL cfg_zero_sweep: got done_ok=%b order=%b f=%h cnt=%0d expected 1/1/0000/16", dn, ord, f, mc);
        end
        do_sweep(1'b0, f, nb, ord, dn, mc);
        tests_run++;
        if (!dn || f !== 16'h0000 || mc !== 5'd16) begin
            tests_failed++;
            $display("FAIL cfg_dropped: got done_ok=%b f=%h cnt=%0d expected 1/0000/16", dn, f, mc);
        end
    endtask

    task automatic test_start_priority;
        int nb; bit ord, fin, extra;
        nb = 0; ord = 1'b1; fin = 1'b0; extra = 1'b0;
        sweep_start = 1'b1; req_valid = 1'b1; req_vec = 4'd5;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_ready: got %b expected 0", req_ready);
        end
        @(negedge clk);
        sweep_start = 1'b0; req_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || rsp_vec !== 4'd0) begin
            tests_failed++;
            $display("FAIL prio_sweep: got busy=%b vec=%0h expected 1/0", busy, rsp_vec);
        end
        for (int c = 0; c < 40 && !fin; c++) begin
            sweep_start = 1'b0;
            if (rsp_valid && busy) begin
                if (rsp_vec != nb[3:0] || req_ready) ord = 1'b0;
                nb++;
                if (nb == 4) sweep_start = 1'b1;
            end else if (sweep_done) begin
                fin = 1'b1;
            end else begin
                ord = 1'b0;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid || busy || sweep_done) extra = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (!fin || nb != 16 || !ord || extra) begin
            tests_failed++;
            $display("FAIL prio_no_restart: got done=%b beats=%0d order=%b extra=%b expected 1/16/1/0", fin, nb, ord, extra);
        end
    endtask

    task automatic test_reset_mid;
        bit hit, done_seen;
        hit = 1'b0; done_seen = 1'b0;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (busy && rsp_vec == 4'd9) hit = 1'b1;
            else @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (!hit || {busy, rsp_valid, sweep_done, rsp_f, rsp_vec, maxterm_cnt} !== 13'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got hit=%b busy=%b vld=%b done=%b vec=%0h cnt=%0d expected 1/0/0/0/0/0",
                     hit, busy, rsp_valid, sweep_done, rsp_vec, maxterm_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sweep_done || busy) done_seen = 1'b1;
        end
        tests_run++;
        if (done_seen || maxterm_cnt !== 5'd0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_after: got activity=%b cnt=%0d rdy=%b expected 0/0/1", done_seen, maxterm_cnt, req_ready);
        end
    endtask

`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
    task automatic test_golden;
        logic [15:0] f; int nb; bit ord, dn; logic [4:0] mc;
        gold_we = 1'b1; gold_tbl = 16'hAAF9;
        @(negedge clk);
        gold_we = 1'b0;
        do_sweep(1'b0, f, nb, ord, dn, mc);
        tests_run++;
        if (!dn || mismatch !== 1'b1 || mismatch_cnt !== 5'd1) begin
            tests_failed++;
            $display("FAIL gold_diff: got done_ok=%b mismatch=%b cnt=%0d expected 1/1/1", dn, mismatch, mismatch_cnt);
        end
        gold_we = 1'b1; gold_tbl = 16'hAAF8;
        @(negedge clk);
        gold_we = 1'b0;
        tests_run++;
        if (mismatch !== 1'b0) begin
            tests_failed++;
            $display("FAIL gold_clear: got %b expected 0", mismatch);
        end
        do_sweep(1'b0, f, nb, ord, dn, mc);
        tests_run++;
        if (!dn || mismatch !== 1'b0 || mismatch_cnt !== 5'd0) begin
            tests_failed++;
            $display("FAIL gold_same: got done_ok=%b mismatch=%b cnt=%0d expected 1/0/0", dn, mismatch, mismatch_cnt);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_default_sweep;
        test_back_to_back;
        test_cfg_write;
        test_start_priority;
        test_reset_mid;
`ifdef FUNC_TABLE_GOLDEN_CHECK_EN
        test_golden;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
